// File: rtl/tileram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tileram_arbiter
//  Purpose  : Single-port slot arbiter for one CY6264 tile RAM. Video tile
//             fetches own any slot they request and complete with fixed
//             latency. CPU reads and writes use a req/ack handshake and fill
//             the slots that video leaves unused. One slot = one CLK_6M cycle.
//  Ports    : CLK_6M, rst (sync, active high)
//             vid_req/vid_addr -> vid_data/vid_valid   video fetch path
//             cpu_req/cpu_we/cpu_addr/cpu_wdata -> cpu_rdata/cpu_ack  CPU bus
//             sram_addr/ce_n/oe_n/we_n/dout/dout_en, sram_din  SRAM pins
//             cpu_starved  sticky starvation flag
//  Options  : TILERAM_ARB_STARVE_MON_EN  enables the CPU starvation monitor;
//             when undefined cpu_starved is tied low.
//  Revision : 1.0  initial release
// ============================================================================
module tileram_arbiter #(
  parameter int ADDR_WIDTH   = 13,
  parameter int DATA_WIDTH   = 8,
  parameter int STARVE_LIMIT = 16
) (
  input  logic                  CLK_6M,
  input  logic                  rst,
  input  logic                  vid_req,
  input  logic [ADDR_WIDTH-1:0] vid_addr,
  output logic [DATA_WIDTH-1:0] vid_data,
  output logic                  vid_valid,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_ack,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n,
  output logic [DATA_WIDTH-1:0] sram_dout,
  output logic                  sram_dout_en,
  input  logic [DATA_WIDTH-1:0] sram_din,
  output logic                  cpu_starved
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_VID    = 2'd1,
    ST_CPU_RD = 2'd2,
    ST_CPU_WR = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic                    w_ack_now;

  logic [DATA_WIDTH-1:0]   r_vid_data;
  logic                    r_vid_valid;
  logic [DATA_WIDTH-1:0]   r_cpu_rdata;
  logic                    r_cpu_ack;
  logic [ADDR_WIDTH-1:0]   r_sram_addr;
  logic                    r_sram_ce_n;
  logic                    r_sram_oe_n;
  logic                    r_sram_we_n;
  logic [DATA_WIDTH-1:0]   r_sram_dout;
  logic                    r_sram_dout_en;

  // A CPU slot ending on this edge is acknowledged on this edge; that same
  // edge must not grant the CPU again, otherwise a request that is still held
  // when the ack appears would be serviced twice.
  assign w_ack_now = (r_state == ST_CPU_RD) || (r_state == ST_CPU_WR);

  always_comb begin
    w_next = ST_IDLE;
    if (vid_req)
      w_next = ST_VID;
    else if (cpu_req && !w_ack_now)
      w_next = cpu_we ? ST_CPU_WR : ST_CPU_RD;
  end

  always_ff @(posedge CLK_6M) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_vid_data     <= '0;
      r_vid_valid    <= 1'b0;
      r_cpu_rdata    <= '0;
      r_cpu_ack      <= 1'b0;
      r_sram_addr    <= '0;
      r_sram_ce_n    <= 1'b1;
      r_sram_oe_n    <= 1'b1;
      r_sram_we_n    <= 1'b1;
      r_sram_dout    <= '0;
      r_sram_dout_en <= 1'b0;
    end else begin
      r_state <= w_next;

      // Exit actions of the slot that ends on this edge.
      r_vid_valid <= (r_state == ST_VID);
      if (r_state == ST_VID)
        r_vid_data <= sram_din;
      r_cpu_ack <= w_ack_now;
      if (r_state == ST_CPU_RD)
        r_cpu_rdata <= sram_din;

      // Entry actions of the slot that starts on this edge.
      case (w_next)
        ST_VID: begin
          r_sram_addr    <= vid_addr;
          r_sram_oe_n    <= 1'b0;
          r_sram_we_n    <= 1'b1;
          r_sram_dout_en <= 1'b0;
          r_sram_ce_n    <= 1'b0;
        end
        ST_CPU_RD: begin
          r_sram_addr    <= cpu_addr;
          r_sram_oe_n    <= 1'b0;
          r_sram_we_n    <= 1'b1;
          r_sram_dout_en <= 1'b0;
          r_sram_ce_n    <= 1'b0;
        end
        ST_CPU_WR: begin
          r_sram_addr    <= cpu_addr;
          r_sram_dout    <= cpu_wdata;
          r_sram_oe_n    <= 1'b1;
          r_sram_we_n    <= 1'b0;
          r_sram_dout_en <= 1'b1;
          r_sram_ce_n    <= 1'b0;
        end
        default: begin
          // Address and write data hold so the bus stays quiet when idle.
          r_sram_oe_n    <= 1'b1;
          r_sram_we_n    <= 1'b1;
          r_sram_dout_en <= 1'b0;
          r_sram_ce_n    <= 1'b1;
        end
      endcase
    end
  end

  assign vid_data     = r_vid_data;
  assign vid_valid    = r_vid_valid;
  assign cpu_rdata    = r_cpu_rdata;
  assign cpu_ack      = r_cpu_ack;
  assign sram_addr    = r_sram_addr;
  assign sram_ce_n    = r_sram_ce_n;
  assign sram_oe_n    = r_sram_oe_n;
  assign sram_we_n    = r_sram_we_n;
  assign sram_dout    = r_sram_dout;
  assign sram_dout_en = r_sram_dout_en;

`ifdef TILERAM_ARB_STARVE_MON_EN
  localparam int                 c_CNT_W    = $clog2(STARVE_LIMIT + 1);
  localparam logic [c_CNT_W-1:0] c_LIMIT    = c_CNT_W'(STARVE_LIMIT);
  localparam logic [c_CNT_W-1:0] c_LIMIT_M1 = c_CNT_W'(STARVE_LIMIT - 1);

  logic [c_CNT_W-1:0] r_starve_cnt;
  logic               r_starved;
  logic               w_denied;

  // A cycle counts as denied only when video takes a slot the CPU wanted;
  // the ack edge of a served access is not a denial.
  assign w_denied = cpu_req && vid_req && !w_ack_now;

  always_ff @(posedge CLK_6M) begin
    if (rst) begin
      r_starve_cnt <= '0;
      r_starved    <= 1'b0;
    end else begin
      if (!w_denied)
        r_starve_cnt <= '0;
      else if (r_starve_cnt != c_LIMIT)
        r_starve_cnt <= r_starve_cnt + 1'b1;
      if (w_denied && (r_starve_cnt >= c_LIMIT_M1))
        r_starved <= 1'b1;
    end
  end

  assign cpu_starved = r_starved;
`else
  logic w_unused_limit;
  assign w_unused_limit = (STARVE_LIMIT != 0);
  assign cpu_starved    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tileram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tileram_arbiter
//  Purpose  : Self-checking bench for tileram_arbiter. A transaction-level
//             reference model with its own memory image predicts every
//             output each cycle; directed scenarios are followed by random
//             video/CPU traffic with occasional resets.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tileram_arbiter;

  localparam int AW = 13;
  localparam int DW = 8;
  localparam int LIMIT = 16;
`ifdef TILERAM_ARB_STARVE_MON_EN
  localparam logic c_MON = 1'b1;
`else
  localparam logic c_MON = 1'b0;
`endif

  logic          CLK_6M = 1'b0;
  logic          rst = 1'b1;
  logic          vid_req = 1'b0;
  logic [AW-1:0] vid_addr = '0;
  logic [DW-1:0] vid_data;
  logic          vid_valid;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ack;
  logic [AW-1:0] sram_addr;
  logic          sram_ce_n, sram_oe_n, sram_we_n, sram_dout_en;
  logic [DW-1:0] sram_dout;
  logic [DW-1:0] sram_din;
  logic          cpu_starved;

  tileram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)) dut (
    .CLK_6M(CLK_6M), .rst(rst),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data), .vid_valid(vid_valid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .sram_addr(sram_addr), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_dout(sram_dout), .sram_dout_en(sram_dout_en),
    .sram_din(sram_din), .cpu_starved(cpu_starved)
  );

  always #5 CLK_6M = ~CLK_6M;

  // Physical SRAM seen by the DUT, and the model's own picture of memory.
  logic [DW-1:0] sram_mem [0:(1<<AW)-1];
  logic [DW-1:0] m_mem    [0:(1<<AW)-1];
  assign sram_din = sram_mem[sram_addr];

  // Strobes captured mid-cycle, committed to the SRAM at the next edge.
  logic          s_we_n = 1'b1, s_ce_n = 1'b1;
  logic [AW-1:0] s_addr = '0;
  logic [DW-1:0] s_dout = '0;

  // Reference model: pending transactions and predicted outputs.
  logic          m_vid_pend, m_cpu_pend, m_cpu_we_p;
  logic [AW-1:0] m_vid_addr_p, m_cpu_addr_p;
  logic [DW-1:0] m_cpu_wdata_p;
  int            m_starve_cnt;
  logic          e_vid_valid, e_ack, e_oe_n, e_we_n, e_ce_n, e_den, e_starved;
  logic [DW-1:0] e_vid_data, e_rdata, e_dout;
  logic [AW-1:0] e_addr;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset_outputs();
    m_vid_pend = 0; m_cpu_pend = 0; m_starve_cnt = 0;
    e_vid_valid = 0; e_vid_data = '0; e_ack = 0; e_rdata = '0;
    e_oe_n = 1; e_we_n = 1; e_ce_n = 1; e_den = 0; e_addr = '0; e_dout = '0;
    e_starved = 0;
  endtask

  // One slot boundary, evaluated from the inputs the DUT just sampled.
  task automatic model_edge();
    logic vg, cg, denied;
    // A write slot that reaches its end edge has had we_n low all slot.
    if (m_cpu_pend && m_cpu_we_p) m_mem[m_cpu_addr_p] = m_cpu_wdata_p;
    if (rst) begin
      model_reset_outputs();
      return;
    end
    e_vid_valid = m_vid_pend;
    if (m_vid_pend) e_vid_data = m_mem[m_vid_addr_p];
    e_ack = m_cpu_pend;
    if (m_cpu_pend && !m_cpu_we_p) e_rdata = m_mem[m_cpu_addr_p];

    vg = vid_req;
    cg = !vid_req && cpu_req && !m_cpu_pend;
    denied = cpu_req && vid_req && !m_cpu_pend;
    if (denied) begin
      m_starve_cnt++;
      if (c_MON && m_starve_cnt >= LIMIT) e_starved = 1;
    end else m_starve_cnt = 0;

    e_oe_n = !(vg || (cg && !cpu_we));
    e_we_n = !(cg && cpu_we);
    e_den  = cg && cpu_we;
    e_ce_n = !(vg || cg);
    if (vg) e_addr = vid_addr;
    else if (cg) e_addr = cpu_addr;
    if (cg && cpu_we) e_dout = cpu_wdata;

    m_vid_pend = vg;     m_vid_addr_p = vid_addr;
    m_cpu_pend = cg;     m_cpu_we_p = cpu_we;
    m_cpu_addr_p = cpu_addr; m_cpu_wdata_p = cpu_wdata;
  endtask

  task automatic tick();
    @(posedge CLK_6M);
    if (!s_we_n && !s_ce_n) sram_mem[s_addr] = s_dout;
    model_edge();
    #1;
    check("vid_valid", vid_valid, e_vid_valid);
    check("vid_data", vid_data, e_vid_data);
    check("cpu_ack", cpu_ack, e_ack);
    check("cpu_rdata", cpu_rdata, e_rdata);
    check("sram_oe_n", sram_oe_n, e_oe_n);
    check("sram_we_n", sram_we_n, e_we_n);
    check("sram_ce_n", sram_ce_n, e_ce_n);
    check("sram_dout_en", sram_dout_en, e_den);
    check("sram_addr", sram_addr, e_addr);
    check("sram_dout", sram_dout, e_dout);
    check("cpu_starved", cpu_starved, e_starved);
    s_we_n = sram_we_n; s_ce_n = sram_ce_n; s_addr = sram_addr; s_dout = sram_dout;
  endtask

  function automatic logic [AW-1:0] pick_addr();
    int k = $urandom_range(0, 9);
    if (k < 8) return AW'(k);
    return (k == 8) ? 13'h1FFF : 13'h0123;
  endfunction

  task automatic new_cpu();
    cpu_req = 1; cpu_we = 1'($urandom_range(0, 1));
    cpu_addr = pick_addr(); cpu_wdata = DW'($urandom);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      sram_mem[i] = DW'($urandom);
      m_mem[i] = sram_mem[i];
    end
    sram_mem[13'h0123] = 8'h5A; m_mem[13'h0123] = 8'h5A;
    model_reset_outputs();

    // Reset held with both requesters active: outputs stay at reset values.
    rst = 1; vid_req = 1; vid_addr = 13'h0042; cpu_req = 1; cpu_we = 0; cpu_addr = 13'h0001;
    repeat (3) tick();
    check("rst_oe_n", sram_oe_n, 1);
    rst = 0; cpu_req = 0;
    tick();                                   // first edge after reset: VID
    check("first_vid_oe_n", sram_oe_n, 0);
    check("first_vid_addr", sram_addr, 13'h0042);
    vid_req = 0;
    repeat (2) tick();

    // Single video fetch of 0x0123 -> 0x5A two edges after the drive edge.
    vid_req = 1; vid_addr = 13'h0123;
    tick();
    check("vf_oe_n", sram_oe_n, 0);
    check("vf_addr", sram_addr, 13'h0123);
    vid_req = 0;
    tick();
    check("vf_valid", vid_valid, 1);
    check("vf_data", vid_data, 8'h5A);
    check("vf_oe_n_off", sram_oe_n, 1);
    tick();
    check("vf_valid_pulse", vid_valid, 0);

    // CPU write 0x1FFF <- 0xA5 then read it back.
    cpu_req = 1; cpu_we = 1; cpu_addr = 13'h1FFF; cpu_wdata = 8'hA5;
    tick();
    check("wr_we_n", sram_we_n, 0);
    check("wr_den", sram_dout_en, 1);
    tick();
    check("wr_ack", cpu_ack, 1);
    check("wr_we_n_rise", sram_we_n, 1);
    check("wr_den_fall", sram_dout_en, 0);
    cpu_req = 0;
    tick();
    cpu_req = 1; cpu_we = 0;
    tick();
    check("rd_ack_early", cpu_ack, 0);
    tick();
    check("rd_ack", cpu_ack, 1);
    check("rd_data", cpu_rdata, 8'hA5);
    cpu_req = 0;
    tick();

    // Video and CPU read together, video held three slots.
    vid_req = 1; vid_addr = 13'h0003; cpu_req = 1; cpu_we = 0; cpu_addr = 13'h0123;
    tick();                                   // N+1
    tick();                                   // N+2
    check("mix_valid_n2", vid_valid, 1);
    tick();                                   // N+3
    check("mix_valid_n3", vid_valid, 1);
    vid_req = 0;
    tick();                                   // N+4
    check("mix_valid_n4", vid_valid, 1);
    check("mix_ack_n4", cpu_ack, 0);
    tick();                                   // N+5
    check("mix_ack_n5", cpu_ack, 1);
    check("mix_rdata", cpu_rdata, 8'h5A);
    cpu_req = 0;
    tick();

    // Reset during a write slot abandons it; reissue completes.
    cpu_req = 1; cpu_we = 1; cpu_addr = 13'h0005; cpu_wdata = 8'h3C;
    tick();
    check("rw_we_n", sram_we_n, 0);
    rst = 1;
    tick();
    check("rw_no_ack", cpu_ack, 0);
    check("rw_we_n_rst", sram_we_n, 1);
    rst = 0;
    tick();
    tick();
    check("rw_reissue_ack", cpu_ack, 1);
    cpu_req = 0;
    tick();

    // Continuous video with a pending CPU request.
    vid_req = 1; cpu_req = 1; cpu_we = 0; cpu_addr = 13'h0002;
    repeat (20) tick();
    check("starve_set", cpu_starved, c_MON);
    vid_req = 0;
    repeat (2) tick();
    check("starve_sticky_ack", cpu_ack, 1);
    check("starve_sticky", cpu_starved, c_MON);
    cpu_req = 0;
    tick();

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 63) == 0);
      vid_req = ($urandom_range(0, 99) < 40);
      vid_addr = pick_addr();
      if (!cpu_req) begin
        if ($urandom_range(0, 1) == 1) new_cpu();
      end else if (e_ack) begin
        if ($urandom_range(0, 1) == 1) cpu_req = 0;
        else new_cpu();
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tileram_arbiter.md
# tileram_arbiter

Single-port arbiter for one CY6264 tile RAM (7N or 4N) in the tile generation subsystem. Shares the SRAM between the video tile fetch path (scroll/tile address generator) and the CPU bus. Video fetches have absolute priority and fixed latency; CPU reads and writes use a req/ack handshake and fill the unused slots. One slot is one CLK_6M cycle.

## Interface
Parameters:
- ADDR_WIDTH, 13, SRAM address width
- DATA_WIDTH, 8, SRAM data width
- STARVE_LIMIT, 16, consecutive denied CPU cycles before cpu_starved sets (monitor build only)

Ports:
- CLK_6M  in  1  sole clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- vid_req  in  1  video fetch request for this slot
- vid_addr  in  ADDR_WIDTH  video fetch address
- vid_data  out  DATA_WIDTH  fetched tile data
- vid_valid  out  1  one-cycle pulse; vid_data valid
- cpu_req  in  1  CPU request; level, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req high
- cpu_addr  in  ADDR_WIDTH  CPU address; stable while cpu_req high
- cpu_wdata  in  DATA_WIDTH  CPU write data; stable while cpu_req high
- cpu_rdata  out  DATA_WIDTH  CPU read data, valid with cpu_ack
- cpu_ack  out  1  one-cycle completion pulse
- sram_addr  out  ADDR_WIDTH  SRAM address
- sram_ce_n, sram_oe_n, sram_we_n  out  1 each  SRAM strobes
- sram_dout  out  DATA_WIDTH  SRAM write data
- sram_dout_en  out  1  SRAM data bus drive enable
- sram_din  in  DATA_WIDTH  SRAM read data
- cpu_starved  out  1  sticky starvation flag (0 when monitor compiled out)

## Operation
- Slot owner state: IDLE, VID, CPU_RD, CPU_WR. Re-evaluated every edge, priority order:
  - vid_req = 1 → VID
  - else cpu_req = 1 and cpu_ack = 0 → CPU_WR if cpu_we else CPU_RD
  - else IDLE
- All SRAM outputs registered on entry to a state:
  - VID / CPU_RD: sram_addr ← address, sram_oe_n = 0, sram_we_n = 1, sram_dout_en = 0.
  - CPU_WR: sram_addr ← cpu_addr, sram_dout ← cpu_wdata, sram_dout_en = 1, sram_we_n = 0, sram_oe_n = 1.
  - IDLE: oe_n = we_n = 1, dout_en = 0, sram_addr holds.
  - sram_ce_n = 0 whenever oe_n or we_n is 0, else 1.
- On exit from a state (the following edge):
  - VID: vid_data ← sram_din, vid_valid = 1.
  - CPU_RD: cpu_rdata ← sram_din, cpu_ack = 1.
  - CPU_WR: cpu_ack = 1.
- vid_data and cpu_rdata hold between updates.
- cpu_ack high blocks CPU grant on that edge, so a request still high after ack is treated as a new request one cycle later.
- Simultaneous vid_req and cpu_req: video wins; CPU waits with no loss of request.
- Reset mid-access: in-flight CPU access abandoned without ack; master must reissue. Reset mid-video: no vid_valid.

## Timing
- Reset values: sram_oe_n = sram_we_n = sram_ce_n = 1, sram_dout_en = 0, sram_addr = 0, sram_dout = 0, vid_valid = 0, vid_data = 0, cpu_ack = 0, cpu_rdata = 0, cpu_starved = 0, state IDLE.
- Video latency fixed: vid_req sampled at edge N → vid_valid and vid_data at edge N+2. Never delayed by CPU traffic, since every access occupies exactly one slot.
- CPU latency: 2 cycles minimum (cpu_req sampled at N → cpu_ack at N+2), plus one cycle per slot taken by video.
- Back-to-back CPU accesses at most every 2 cycles. Continuous vid_req starves the CPU indefinitely by design.
- Write: sram_we_n low exactly one cycle. sram_dout_en falls on the same edge as sram_we_n rises.

## Configuration
- TILERAM_ARB_STARVE_MON_EN defined:
  - Saturating counter of consecutive cycles with cpu_req = 1 and no CPU grant; cleared on grant or when cpu_req = 0.
  - On reaching STARVE_LIMIT, cpu_starved sets and stays set until rst.
- Undefined: counter absent; cpu_starved tied to 0.

## Test plan
- Reset with vid_req = cpu_req = 1 held → all outputs at reset values; first grant (VID) occurs on the first edge after rst falls.
- vid_req pulse, vid_addr = 0x0123, sram_din = 0x5A → sram_oe_n low one cycle with sram_addr = 0x0123; vid_valid and vid_data = 0x5A at N+2.
- CPU write 0x1FFF ← 0xA5, then read 0x1FFF with a memory model → one we_n pulse, dout_en coincident with it; read returns cpu_rdata = 0xA5; each ack 2 cycles after its request.
- vid_req and cpu_req (read) rise together, vid_req held 3 cycles → three VID slots, then CPU_RD; cpu_ack at N+5; vid_valid uninterrupted at N+2..N+4.
- rst asserted during a CPU_WR slot → no cpu_ack; we_n returns to 1 the next edge; reissued write completes normally.
- Macro defined, STARVE_LIMIT = 16, vid_req held 20 cycles with cpu_req high → cpu_starved = 1 after 16 denied cycles and stays 1 after the CPU is served; macro undefined → stays 0.
